// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between two writeback requesters.
// Zero-fills the file after reset, then round-robin arbitrates and flags handshake violations.
module rf_write_arbiter #(
  parameter int DATA_W        = 16,
  parameter int REG_W         = 3,
  parameter int NUM_REGS      = 8,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [REG_W-1:0]  req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [REG_W-1:0]  req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [REG_W-1:0]  writeRegSel,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEn,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] S_RESET_HOLD = 2'd0;
  localparam logic [1:0] S_INIT       = 2'd1;
  localparam logic [1:0] S_ARB        = 2'd2;
  localparam logic [1:0] S_START      = (INIT_ON_RESET != 0) ? S_INIT : S_ARB;

  logic [1:0]        r_state;
  logic [1:0]        w_state;
  logic [REG_W-1:0]  r_cnt;
  logic              r_rr;
  logic              r_err;
  logic              r_pend0, r_pend1;
  logic [REG_W-1:0]  r_reg0, r_reg1;
  logic [DATA_W-1:0] r_data0, r_data1;
  logic              w_init, w_arb, w_g0, w_g1;
  logic              w_viol0, w_viol1;

  // Reset overrides the registered state so every output is quiet while rst is high.
  always_comb begin
    w_state = rst ? S_RESET_HOLD : r_state;
    w_init  = (w_state == S_INIT);
    w_arb   = (w_state == S_ARB);
    w_g0    = w_arb & req0_valid & (~req1_valid | ~r_rr);
    w_g1    = w_arb & req1_valid & (~req0_valid |  r_rr);
    w_viol0 = r_pend0 & (~req0_valid | (req0_reg != r_reg0) | (req0_data != r_data0));
    w_viol1 = r_pend1 & (~req1_valid | (req1_reg != r_reg1) | (req1_data != r_data1));
  end

  always_comb begin
    req0_ready  = w_g0;
    req1_ready  = w_g1;
    busy        = w_init;
    err         = r_err & ~rst;
    writeEn     = w_init | w_g0 | w_g1;
    writeRegSel = '0;
    writeData   = '0;
    if (w_init) begin
      writeRegSel = r_cnt;
    end else if (w_g0) begin
      writeRegSel = req0_reg;
      writeData   = req0_data;
    end else if (w_g1) begin
      writeRegSel = req1_reg;
      writeData   = req1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_START;
      r_cnt   <= '0;
      r_rr    <= 1'b0;
      r_err   <= 1'b0;
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_reg0  <= '0;
      r_reg1  <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      if (r_state == S_INIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == REG_W'(NUM_REGS - 1))
          r_state <= S_ARB;
      end
      // Pointer moves only on contention and always lands on the loser.
      if (w_arb & req0_valid & req1_valid)
        r_rr <= w_g0;
      if (w_viol0 | w_viol1)
        r_err <= 1'b1;
      r_pend0 <= req0_valid & ~w_g0;
      r_pend1 <= req1_valid & ~w_g1;
      r_reg0  <= req0_reg;
      r_reg1  <= req1_reg;
      r_data0 <= req0_data;
      r_data1 <= req1_data;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a transaction-level model predicts every write,
// a negedge monitor pops and compares whenever the DUT asserts writeEn.
module tb_rf_write_arbiter;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [RW-1:0] req0_reg = '0, req1_reg = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, writeEn, busy, err;
  logic [RW-1:0] writeRegSel;
  logic [DW-1:0] writeData;

  rf_write_arbiter #(.DATA_W(DW), .REG_W(RW), .NUM_REGS(NR), .INIT_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] sel;
    logic [DW-1:0] data;
    logic          r0;
    logic          r1;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;

  bit            act[2];
  logic [RW-1:0] rq_reg[2];
  logic [DW-1:0] rq_dat[2];

  int            init_left;
  int            fav;
  bit            m_err;
  bit            m_pend[2];
  logic [RW-1:0] m_preg[2];
  logic [DW-1:0] m_pdat[2];
  logic [DW-1:0] rf_m[NR];
  logic [DW-1:0] rf_obs[NR];
  int            lose;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic drive();
    req0_valid = act[0]; req0_reg = rq_reg[0]; req0_data = rq_dat[0];
    req1_valid = act[1]; req1_reg = rq_reg[1]; req1_data = rq_dat[1];
  endtask

  task automatic gen(input int pct);
    for (int i = 0; i < 2; i++)
      if (!act[i] && $urandom_range(99) < pct) begin
        act[i]    = 1'b1;
        rq_reg[i] = RW'($urandom);
        rq_dat[i] = DW'($urandom);
      end
  endtask

  task automatic rst_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst = 1'b1;
      drive();
      init_left = NR;
      fav       = 0;
      m_err     = 1'b0;
      m_pend[0] = 1'b0;
      m_pend[1] = 1'b0;
      #1;
      check("reset_outputs",
            64'({writeEn, req0_ready, req1_ready, busy, err, writeRegSel, writeData}), 64'(0));
    end
  endtask

  // One clock of stimulus plus the model's prediction for that same cycle.
  task automatic step();
    int  g;
    bit  viol;
    bit  exp_busy;
    wr_t w;
    @(posedge clk); #1;
    rst = 1'b0;
    drive();
    g = -1; viol = 1'b0; exp_busy = 1'b0;
    if (init_left > 0) begin
      w.sel = RW'(NR - init_left); w.data = '0; w.r0 = 1'b0; w.r1 = 1'b0;
      exp_q.push_back(w);
      rf_m[w.sel] = '0;
      init_left--;
      exp_busy = 1'b1;
    end else begin
      if (act[0] && act[1]) begin g = fav; fav = 1 - fav; end
      else if (act[0]) g = 0;
      else if (act[1]) g = 1;
      if (g >= 0) begin
        w.sel = rq_reg[g]; w.data = rq_dat[g]; w.r0 = (g == 0); w.r1 = (g == 1);
        exp_q.push_back(w);
        rf_m[w.sel] = w.data;
      end
    end
    for (int i = 0; i < 2; i++)
      if (m_pend[i] && (!act[i] || rq_reg[i] !== m_preg[i] || rq_dat[i] !== m_pdat[i]))
        viol = 1'b1;
    #1;
    check("status", 64'({req0_ready, req1_ready, busy, err}),
          64'({g == 0, g == 1, exp_busy, m_err}));
    if (viol) m_err = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = act[i] && (g != i);
      m_preg[i] = rq_reg[i];
      m_pdat[i] = rq_dat[i];
    end
    if (g >= 0) act[g] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (writeEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got sel %0h data %0h expected no write at %0t",
                 writeRegSel, writeData, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", 64'({writeRegSel, writeData, req0_ready, req1_ready}), 64'(mon_e));
      end
      rf_obs[writeRegSel] = writeData;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin rf_m[i] = 'x; rf_obs[i] = 'x; end
    act[0] = 1'b0; act[1] = 1'b0;
    rq_reg[0] = '0; rq_reg[1] = '0; rq_dat[0] = '0; rq_dat[1] = '0;
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;

    rst_cycles(2);
    repeat (NR) step();
    step();

    // same destination from both sides: winner first, loser's data lands last
    act[0] = 1'b1; rq_reg[0] = 3'd5; rq_dat[0] = 16'h00AA;
    act[1] = 1'b1; rq_reg[1] = 3'd5; rq_dat[1] = 16'h00BB;
    step();
    @(negedge clk); #1;
    check("r5_after_first", 64'(rf_obs[5]), 64'(16'h00AA));
    step();
    @(negedge clk); #1;
    check("r5_after_second", 64'(rf_obs[5]), 64'(16'h00BB));

    act[0] = 1'b1; rq_reg[0] = 3'd3; rq_dat[0] = 16'hBEEF;
    step();
    @(negedge clk); #1;
    check("r3_single", 64'(rf_obs[3]), 64'(16'hBEEF));

    repeat (10) begin gen(100); step(); end
    repeat (300) begin gen(40); step(); end
    for (int k = 0; k < 4 && (act[0] || act[1]); k++) step();
    step();

    // loser changes its data while still waiting
    act[0] = 1'b1; rq_reg[0] = 3'd1; rq_dat[0] = 16'h1111;
    act[1] = 1'b1; rq_reg[1] = 3'd2; rq_dat[1] = 16'h2222;
    lose = 1 - fav;
    step();
    rq_dat[lose] = 16'h1234;
    repeat (12) step();
    check("err_sticky", 64'(err), 64'(1));

    rst_cycles(1);
    repeat (NR) step();
    step();

    // loser drops valid while still waiting
    act[0] = 1'b1; rq_reg[0] = 3'd4; rq_dat[0] = 16'h4444;
    act[1] = 1'b1; rq_reg[1] = 3'd7; rq_dat[1] = 16'h7777;
    lose = 1 - fav;
    step();
    act[lose] = 1'b0;
    repeat (11) step();

    // reset in the middle of the zero-fill, with a request held through the restart
    rst_cycles(2);
    repeat (4) step();
    rst_cycles(1);
    act[0] = 1'b1; rq_reg[0] = 3'd6; rq_dat[0] = 16'hC0DE;
    repeat (NR) step();
    step();
    step();

    @(negedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    for (int i = 0; i < NR; i++)
      check("rf_final", 64'(rf_obs[i]), 64'(rf_m[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
